// File: rtl/cache_mem_arbiter.sv
// Shares one pipelined main memory between the I- and D-cache: 8-word block fills and single-word stores.
// Optional `ARB_ROUND_ROBIN_EN: contested I/D misses alternate owner instead of D-first.
module cache_mem_arbiter #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LATENCY     = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_miss,
    input  logic [15:0]                        i_miss_addr,
    input  logic                               d_miss,
    input  logic [15:0]                        d_miss_addr,
    input  logic                               d_wr_req,
    input  logic [15:0]                        d_wr_addr,
    input  logic [15:0]                        d_wr_data,
    output logic                               d_wr_ack,
    output logic                               mem_enable,
    output logic                               mem_wr,
    output logic [15:0]                        mem_addr,
    output logic [15:0]                        mem_data_in,
    input  logic [15:0]                        mem_data_out,
    input  logic                               mem_data_valid,
    output logic [15:0]                        fill_data,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word,
    output logic                               i_fill_we,
    output logic                               d_fill_we,
    output logic                               i_fill_done,
    output logic                               d_fill_done,
    output logic                               busy
);

    localparam int            CW        = $clog2(WORDS_PER_BLOCK);
    localparam logic [CW:0]   BLK_WORDS = (CW+1)'(WORDS_PER_BLOCK);
    localparam logic [CW-1:0] LAST_WORD = CW'(WORDS_PER_BLOCK - 1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FILL, S_DONE} state_t;

    state_t        state_q, state_d;
    logic          owner_i_q, owner_i_d;
    logic [15:0]   base_q, base_d;
    logic [CW:0]   issue_cnt_q, issue_cnt_d;
    logic [CW-1:0] recv_cnt_q, recv_cnt_d;
    logic          fill_start;
    logic          pick_i;

    // Block offset bits of the miss addresses are dropped; latency is tracked via mem_data_valid.
    logic unused_bits;
    assign unused_bits = ^{i_miss_addr[3:0], d_miss_addr[3:0], 32'(MEM_LATENCY)};

    assign fill_start = (state_q == S_IDLE) && !d_wr_req && (d_miss || i_miss);

`ifdef ARB_ROUND_ROBIN_EN
    logic prefer_i_q, prefer_i_d;

    assign pick_i = i_miss && (!d_miss || prefer_i_q);

    // Preference flips only when both caches compete, so the loser wins next time.
    always_comb begin
        prefer_i_d = prefer_i_q;
        if (fill_start && d_miss && i_miss) begin
            prefer_i_d = !pick_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prefer_i_q <= 1'b0;
        end else begin
            prefer_i_q <= prefer_i_d;
        end
    end
`else
    assign pick_i = i_miss && !d_miss;
`endif

    always_comb begin
        state_d     = state_q;
        owner_i_d   = owner_i_q;
        base_d      = base_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        d_wr_ack    = 1'b0;
        mem_enable  = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = 16'h0000;
        mem_data_in = 16'h0000;
        fill_data   = 16'h0000;
        fill_word   = '0;
        i_fill_we   = 1'b0;
        d_fill_we   = 1'b0;
        i_fill_done = 1'b0;
        d_fill_done = 1'b0;
        busy        = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (d_wr_req) begin
                    state_d = S_WRITE;
                end else if (fill_start) begin
                    state_d     = S_FILL;
                    owner_i_d   = pick_i;
                    base_d      = pick_i ? {i_miss_addr[15:4], 4'h0} : {d_miss_addr[15:4], 4'h0};
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                end
            end
            S_WRITE: begin
                mem_enable  = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = d_wr_addr;
                mem_data_in = d_wr_data;
                d_wr_ack    = 1'b1;
                state_d     = S_IDLE;
            end
            S_FILL: begin
                // Issue and receive sides run independently; returns overlap later issues.
                if (issue_cnt_q < BLK_WORDS) begin
                    mem_enable  = 1'b1;
                    mem_addr    = base_q + 16'({issue_cnt_q[CW-1:0], 1'b0});
                    issue_cnt_d = issue_cnt_q + (CW+1)'(1);
                end
                if (mem_data_valid) begin
                    fill_data  = mem_data_out;
                    fill_word  = recv_cnt_q;
                    i_fill_we  = owner_i_q;
                    d_fill_we  = !owner_i_q;
                    recv_cnt_d = recv_cnt_q + CW'(1);
                    if (recv_cnt_q == LAST_WORD) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                i_fill_done = owner_i_q;
                d_fill_done = !owner_i_q;
                issue_cnt_d = '0;
                recv_cnt_d  = '0;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_i_q   <= 1'b0;
            base_q      <= 16'h0000;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_i_q   <= owner_i_d;
            base_q      <= base_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: latency-4 memory model, transaction-timeline reference model,
// per-cycle output compare plus directed literal checks. Honours `ARB_ROUND_ROBIN_EN.
`timescale 1ns/1ps
module tb_cache_mem_arbiter;

    logic        clk, rst;
    logic        i_miss, d_miss, d_wr_req;
    logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
    logic        d_wr_ack, mem_enable, mem_wr;
    logic [15:0] mem_addr, mem_data_in, mem_data_out, fill_data;
    logic        mem_data_valid;
    logic [2:0]  fill_word;
    logic        i_fill_we, d_fill_we, i_fill_done, d_fill_done, busy;

    cache_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_miss(i_miss), .i_miss_addr(i_miss_addr),
        .d_miss(d_miss), .d_miss_addr(d_miss_addr),
        .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
        .d_wr_ack(d_wr_ack),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .mem_data_valid(mem_data_valid),
        .fill_data(fill_data), .fill_word(fill_word),
        .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
        .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
        .busy(busy)
    );

    typedef struct packed {
        logic        ack, en, wr;
        logic [15:0] addr, wdata, fdata;
        logic [2:0]  fword;
        logic        iwe, dwe, idone, ddone, busy;
    } outv_t;

    outv_t act_now;
    assign act_now = {d_wr_ack, mem_enable, mem_wr, mem_addr, mem_data_in, fill_data,
                      fill_word, i_fill_we, d_fill_we, i_fill_done, d_fill_done, busy};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    outv_t       exp_q[$];
    outv_t       m_exp;
    bit          m_prefer_i;
    logic        pv[4];
    logic [15:0] pd[4];

    logic [15:0] iss_addr_q[$];
    int          iss_cyc_q[$];
    bit          we_own_q[$];
    logic [2:0]  we_word_q[$];
    logic [15:0] we_data_q[$];
    int          we_cyc_q[$];
    bit          done_own_q[$];
    int          done_cyc_q[$];
    logic [15:0] wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    int          wr_cyc_q[$];
    int          ack_cnt, valid_cnt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // A fill is a fixed 13-cycle timeline: 8 issues, data from relative cycle 4 to 11, done at 12.
    function automatic void sched_fill(input bit own_i, input logic [15:0] a);
        logic [15:0] b;
        outv_t e;
        b = {a[15:4], 4'h0};
        for (int j = 0; j < 13; j++) begin
            e = '0;
            e.busy = 1'b1;
            if (j < 8) begin
                e.en   = 1'b1;
                e.addr = b + 16'(2 * j);
            end
            if (j >= 4 && j < 12) begin
                e.fdata = mem_val(b + 16'(2 * (j - 4)));
                e.fword = 3'(j - 4);
                e.iwe   = own_i;
                e.dwe   = !own_i;
            end
            if (j == 12) begin
                e.idone = own_i;
                e.ddone = !own_i;
            end
            exp_q.push_back(e);
        end
    endfunction

    function automatic void model_decide();
        outv_t e;
        bit    own_i;
        if (d_wr_req) begin
            e = '0;
            e.ack = 1'b1; e.en = 1'b1; e.wr = 1'b1; e.busy = 1'b1;
            e.addr = d_wr_addr; e.wdata = d_wr_data;
            exp_q.push_back(e);
        end else if (d_miss && i_miss) begin
`ifdef ARB_ROUND_ROBIN_EN
            own_i = m_prefer_i;
            m_prefer_i = !own_i;
`else
            own_i = 1'b0;
`endif
            sched_fill(own_i, own_i ? i_miss_addr : d_miss_addr);
        end else if (d_miss) begin
            sched_fill(1'b0, d_miss_addr);
        end else if (i_miss) begin
            sched_fill(1'b1, i_miss_addr);
        end
    endfunction

    // Pipelined memory: a read issued in cycle c is returned valid in cycle c+4.
    always @(negedge clk) begin
        mem_data_valid = pv[3];
        mem_data_out   = pv[3] ? pd[3] : 16'h5A5A;
        for (int k = 3; k > 0; k--) begin
            pv[k] = pv[k-1];
            pd[k] = pd[k-1];
        end
        pv[0] = mem_enable && !mem_wr;
        pd[0] = mem_val(mem_addr);
    end

    always @(negedge clk) begin
        #1;
        cyc++;
        if (rst) begin
            exp_q.delete();
            m_exp = '0;
            m_prefer_i = 1'b0;
        end else if (exp_q.size() == 0) begin
            m_exp = '0;
            model_decide();
        end else begin
            m_exp = exp_q.pop_front();
        end
        chk("cycle_outputs", 64'(act_now), 64'(m_exp));
        if (mem_data_valid) valid_cnt++;
        if (mem_enable && !mem_wr) begin
            iss_addr_q.push_back(mem_addr);
            iss_cyc_q.push_back(cyc);
        end
        if (mem_enable && mem_wr) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_data_in);
            wr_cyc_q.push_back(cyc);
        end
        if (i_fill_we || d_fill_we) begin
            we_own_q.push_back(i_fill_we);
            we_word_q.push_back(fill_word);
            we_data_q.push_back(fill_data);
            we_cyc_q.push_back(cyc);
        end
        if (i_fill_done || d_fill_done) begin
            done_own_q.push_back(i_fill_done);
            done_cyc_q.push_back(cyc);
        end
        if (d_wr_ack) ack_cnt++;
    end

    task automatic clear_logs();
        iss_addr_q.delete(); iss_cyc_q.delete();
        we_own_q.delete(); we_word_q.delete(); we_data_q.delete(); we_cyc_q.delete();
        done_own_q.delete(); done_cyc_q.delete();
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        ack_cnt = 0;
        valid_cnt = 0;
    endtask

    task automatic serve_i(input logic [15:0] a);
        bit seen = 1'b0;
        i_miss_addr = a;
        i_miss = 1'b1;
        for (int n = 0; n < 80 && !seen; n++) begin
            @(negedge clk); #2;
            seen = i_fill_done;
        end
        chk("i_fill_done_seen", 64'(seen), 64'd1);
        @(posedge clk); #1;
        i_miss = 1'b0;
    endtask

    task automatic serve_d(input logic [15:0] a);
        bit seen = 1'b0;
        d_miss_addr = a;
        d_miss = 1'b1;
        for (int n = 0; n < 80 && !seen; n++) begin
            @(negedge clk); #2;
            seen = d_fill_done;
        end
        chk("d_fill_done_seen", 64'(seen), 64'd1);
        @(posedge clk); #1;
        d_miss = 1'b0;
    endtask

    task automatic serve_w(input logic [15:0] a, input logic [15:0] d);
        bit seen = 1'b0;
        d_wr_addr = a;
        d_wr_data = d;
        d_wr_req = 1'b1;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk); #2;
            seen = d_wr_ack;
        end
        chk("d_wr_ack_seen", 64'(seen), 64'd1);
        @(posedge clk); #1;
        d_wr_req = 1'b0;
    endtask

    task automatic check_pair(input bit first_i, input int req, input logic [15:0] second_base,
                              input logic [15:0] first_word0);
        int wrong_owner = 0;
        chk("pair_done_count", done_own_q.size(), 2);
        chk("pair_first_owner", 64'(done_own_q[0]), 64'(first_i));
        chk("pair_second_owner", 64'(done_own_q[1]), 64'(!first_i));
        chk("pair_first_done_cycle", done_cyc_q[0], req + 13);
        for (int k = 0; k < we_own_q.size(); k++) begin
            if (we_cyc_q[k] < done_cyc_q[0] && we_own_q[k] != first_i) wrong_owner++;
        end
        chk("pair_no_second_we_during_first", wrong_owner, 0);
        chk("pair_first_word0_data", we_data_q[0], first_word0);
        chk("pair_second_first_addr", iss_addr_q[8], second_base);
        chk("pair_second_start_cycle", iss_cyc_q[8], req + 15);
        chk("pair_second_done_cycle", done_cyc_q[1], req + 27);
    endtask

    initial begin
        int  req;
        bit  got3;
        logic second_first;
        rst = 1'b1;
        i_miss = 1'b0; d_miss = 1'b0; d_wr_req = 1'b0;
        i_miss_addr = 16'h0; d_miss_addr = 16'h0; d_wr_addr = 16'h0; d_wr_data = 16'h0;
        mem_data_valid = 1'b0; mem_data_out = 16'h0;
        for (int k = 0; k < 4; k++) begin
            pv[k] = 1'b0;
            pd[k] = 16'h0;
        end
        clear_logs();
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        chk("reset_outputs", 64'(act_now), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // I-miss at 0x1236: base 0x1230, done 13 cycles after the request.
        clear_logs();
        req = cyc + 1;
        serve_i(16'h1236);
        chk("imiss_issue_count", iss_addr_q.size(), 8);
        chk("imiss_we_count", we_own_q.size(), 8);
        for (int k = 0; k < 8; k++) begin
            chk("imiss_addr", iss_addr_q[k], 16'h1230 + 16'(2 * k));
            chk("imiss_issue_cycle", iss_cyc_q[k], req + 1 + k);
            chk("imiss_word", we_word_q[k], k);
            chk("imiss_we_owner_i", 64'(we_own_q[k]), 64'd1);
            chk("imiss_we_cycle", we_cyc_q[k], req + 5 + k);
        end
        chk("imiss_word0_data", we_data_q[0], 16'hB7F3);
        chk("imiss_last_addr", iss_addr_q[7], 16'h123E);
        chk("imiss_done_cycle", done_cyc_q[0], req + 13);

        // Simultaneous D@0x4000 and I@0x0020: D first in both builds.
        clear_logs();
        req = cyc + 1;
        fork
            serve_d(16'h4000);
            serve_i(16'h0020);
        join
        check_pair(1'b0, req, 16'h0020, 16'hE5C3);

        // Second simultaneous pair: round robin hands it to I.
`ifdef ARB_ROUND_ROBIN_EN
        second_first = 1'b1;
`else
        second_first = 1'b0;
`endif
        clear_logs();
        req = cyc + 1;
        fork
            serve_d(16'h4000);
            serve_i(16'h0020);
        join
        check_pair(second_first, req, second_first ? 16'h4000 : 16'h0020,
                   second_first ? 16'hA5E3 : 16'hE5C3);

        // Store 0xBEEF to 0x0104 while an I-miss is pending: write goes first.
        clear_logs();
        req = cyc + 1;
        fork
            serve_w(16'h0104, 16'hBEEF);
            serve_i(16'h2008);
        join
        chk("store_count", wr_addr_q.size(), 1);
        chk("store_addr", wr_addr_q[0], 16'h0104);
        chk("store_data", wr_data_q[0], 16'hBEEF);
        chk("store_cycle", wr_cyc_q[0], req + 1);
        chk("store_ack_count", ack_cnt, 1);
        chk("store_then_fill_addr", iss_addr_q[0], 16'h2000);
        chk("store_then_fill_cycle", iss_cyc_q[0], req + 3);
        chk("store_then_fill_done", done_cyc_q[0], req + 15);

        // Top of memory: no wrap, no ninth access.
        clear_logs();
        serve_i(16'hFFFF);
        chk("top_issue_count", iss_addr_q.size(), 8);
        chk("top_first_addr", iss_addr_q[0], 16'hFFF0);
        chk("top_last_addr", iss_addr_q[7], 16'hFFFE);
        for (int k = 1; k < iss_addr_q.size(); k++) begin
            chk("top_addr_step", iss_addr_q[k], iss_addr_q[k-1] + 16'd2);
        end

        // Reset after three data words of an I-fill.
        clear_logs();
        i_miss_addr = 16'h5000;
        i_miss = 1'b1;
        got3 = 1'b0;
        for (int n = 0; n < 40 && !got3; n++) begin
            @(negedge clk); #2;
            got3 = (we_own_q.size() >= 3);
        end
        chk("reset_prefill_three_words", 64'(got3), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        i_miss = 1'b0;
        #1;
        chk("reset_mid_fill_outputs", 64'(act_now), 64'd0);
        clear_logs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("stray_valid_no_fill_we", we_own_q.size(), 0);
        chk("stray_valid_present", 64'(valid_cnt > 0), 64'd1);
        clear_logs();
        req = cyc + 1;
        serve_i(16'h5000);
        chk("restart_we_count", we_own_q.size(), 8);
        chk("restart_word0", we_word_q[0], 0);
        chk("restart_first_addr", iss_addr_q[0], 16'h5000);
        chk("restart_done_cycle", done_cyc_q[0], req + 13);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
